ram_port_arbiter: RTL and testbench
===================================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameters ADDR_WIDTH=16, DATA_WIDTH=32, BYTE_WIDTH=8 and BATCH_WIDTH=DATA_WIDTH/BYTE_WIDTH, which set the RAM word, address and byte-enable widths.
REQ-003 Port: clk, input, 1, single clock; all logic on rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: req_valid, input, NUM_REQ, per-requester beat request.
REQ-006 Port: req_ready, output, NUM_REQ, per-requester beat accept.
REQ-007 Port: req_we, input, NUM_REQ, 1 = write beat, 0 = read beat.
REQ-008 Port: req_last, input, NUM_REQ, final beat of the requester's burst.
REQ-009 Port: req_addr, input, NUM_REQ x ADDR_WIDTH, beat word address.
REQ-010 Port: req_wdata, input, NUM_REQ x DATA_WIDTH, write data.
REQ-011 Port: req_byte_en, input, NUM_REQ x BATCH_WIDTH, write byte strobes.
REQ-012 Port: rsp_valid, output, NUM_REQ, read data valid for that requester.
REQ-013 Port: rsp_data, output, DATA_WIDTH, read data, shared by all requesters.
REQ-014 Ports ram_addr (output, ADDR_WIDTH), ram_write (output, DATA_WIDTH), ram_write_en (output, 1), ram_byte_en (output, BATCH_WIDTH) and ram_data (input, DATA_WIDTH) SHALL drive one synchronous RAM port; ram_data arrives with 1-cycle read latency.

Function
REQ-015 A beat SHALL be accepted for requester i in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-016 At most one req_ready bit SHALL be high per cycle.
REQ-017 req_ready SHALL depend combinationally on req_valid, the FSM state and rr_ptr, so an idle arbiter grants in the same cycle.
REQ-018 The FSM SHALL have two states, IDLE and LOCKED, plus registers owner and rr_ptr (both $clog2(NUM_REQ) wide).
REQ-019 In IDLE, the winner SHALL be the first i with req_valid[i]=1, searching upward from rr_ptr with wrap modulo NUM_REQ; only the winner gets req_ready=1.
REQ-020 In IDLE, if the winner's beat has req_last=0, the FSM SHALL go to LOCKED with owner set to the winner.
REQ-021 In IDLE, if the winner's beat has req_last=1, the FSM SHALL stay in IDLE and rr_ptr SHALL become (winner+1) mod NUM_REQ.
REQ-022 In LOCKED, req_ready SHALL equal req_valid[owner] for the owner and 0 for every other requester.
REQ-023 In LOCKED, an accepted owner beat with req_last=1 SHALL return the FSM to IDLE and set rr_ptr to (owner+1) mod NUM_REQ.
REQ-024 If the owner drops req_valid while LOCKED, the FSM SHALL stay LOCKED with the RAM port idle; there is no timeout.
REQ-025 On an accepted beat, ram_addr SHALL equal the granted req_addr in the same cycle.
REQ-026 On an accepted write beat, ram_write_en=1, ram_byte_en=granted req_byte_en and ram_write=granted req_wdata.
REQ-027 On an accepted read beat, ram_write_en=0 and ram_byte_en=0.
REQ-028 With no accepted beat, ram_addr, ram_write, ram_write_en and ram_byte_en SHALL all be 0.
REQ-029 rsp_valid[i] SHALL be registered and equal 1 exactly one cycle after an accepted read beat of requester i; otherwise 0.
REQ-030 rsp_data SHALL equal ram_data combinationally; there is no response backpressure.
REQ-031 When all requesters are valid with req_last=1 on every beat, grants SHALL rotate 0,1,..,NUM_REQ-1,0, one beat per cycle.
REQ-032 rr_ptr wrap from NUM_REQ-1 to 0 SHALL hold for non-power-of-two NUM_REQ.

Reset
REQ-033 While rst=1, state SHALL be IDLE, owner=0, rr_ptr=0, and rsp_valid, req_ready and all ram_* outputs SHALL be 0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no pending rsp_valid.
REQ-035 After rst deasserts, the first arbitration SHALL search from requester 0.

Structure
REQ-036 Package ram_arb_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the default width constants.
REQ-037 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs req vector and pointer; outputs one-hot grant and index).

Verification
REQ-038 Single read: rst, then req0 read addr 0x0010 last=1 -> ready0 same cycle, ram_addr=0x0010, rsp_valid0=1 next cycle with rsp_data=RAM[0x10].
REQ-039 Contention: req0..3 all valid, last=1 each beat, for 8 cycles -> grant order 0,1,2,3,0,1,2,3; ram_write_en follows req_we.
REQ-040 Burst lock: req1 4-beat write addr 0x20..0x23 with req2 continuously valid -> ready2=0 for all 4 beats; req2 granted on cycle 5; rr_ptr=2 after the burst.
REQ-041 Owner stall: req3 burst with valid low 3 cycles mid-burst while req0 valid -> ready0 stays 0 and ram_write_en=0 during the gap.
REQ-042 Reset mid-burst: assert rst during beat 2 of a req1 read burst -> all outputs 0 immediately, no rsp_valid afterwards, next grant goes to req0 when req0 and req1 are both valid.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned NumReqDefault    = 4;
  localparam int unsigned AddrWidthDefault = 16;
  localparam int unsigned DataWidthDefault = 32;
  localparam int unsigned ByteWidthDefault = 8;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  int              j;
  logic [IdxW-1:0] jj;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    jj    = '0;
    // Scan from the farthest offset down so the nearest request wins last.
    for (int off = int'(N) - 1; off >= 0; off--) begin
      j = int'(ptr_i) + off;
      if (j >= int'(N)) j = j - int'(N);
      jj = IdxW'(j);
      if (req_i[jj]) begin
        gnt_o     = '0;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NUM_REQ beat requesters onto one synchronous RAM port, locking on bursts.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NumReqDefault,
  parameter int unsigned ADDR_WIDTH  = AddrWidthDefault,
  parameter int unsigned DATA_WIDTH  = DataWidthDefault,
  parameter int unsigned BYTE_WIDTH  = ByteWidthDefault,
  parameter int unsigned BATCH_WIDTH = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ-1:0]                  req_last,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0][BATCH_WIDTH-1:0] req_byte_en,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [ADDR_WIDTH-1:0]               ram_addr,
  output logic [DATA_WIDTH-1:0]               ram_write,
  output logic                                ram_write_en,
  output logic [BATCH_WIDTH-1:0]              ram_byte_en,
  input  logic [DATA_WIDTH-1:0]               ram_data
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;
  logic [IdxW-1:0]    gnt_idx;
  logic               accept;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(NUM_REQ - 1)) ? '0 : i + IdxW'(1);
  endfunction

  rr_pick #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    req_ready = '0;
    gnt_idx   = '0;
    accept    = 1'b0;
    // Outputs are forced quiet while reset is held, not just after the edge.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            req_ready = pick_gnt;
            gnt_idx   = pick_idx;
            accept    = 1'b1;
            if (req_last[pick_idx]) begin
              rr_ptr_d = next_idx(pick_idx);
            end else begin
              state_d = StLocked;
              owner_d = pick_idx;
            end
          end
        end
        StLocked: begin
          if (req_valid[owner_q]) begin
            req_ready[owner_q] = 1'b1;
            gnt_idx            = owner_q;
            accept             = 1'b1;
            if (req_last[owner_q]) begin
              state_d  = StIdle;
              rr_ptr_d = next_idx(owner_q);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    ram_addr     = '0;
    ram_write    = '0;
    ram_write_en = 1'b0;
    ram_byte_en  = '0;
    rsp_valid_d  = '0;
    if (accept) begin
      ram_addr = req_addr[gnt_idx];
      if (req_we[gnt_idx]) begin
        ram_write_en = 1'b1;
        ram_byte_en  = req_byte_en[gnt_idx];
        ram_write    = req_wdata[gnt_idx];
      end else begin
        rsp_valid_d = req_ready;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = ram_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench: fixed vector table, directed single read, then random traffic vs model.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_wdata;
  logic [N-1:0][BW-1:0]   req_byte_en;
  logic [DW-1:0]          rsp_data, ram_write, ram_data;
  logic [AW-1:0]          ram_addr;
  logic                   ram_write_en;
  logic [BW-1:0]          ram_byte_en;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BYTE_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_last     (req_last),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_byte_en  (req_byte_en),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .ram_addr     (ram_addr),
    .ram_write    (ram_write),
    .ram_write_en (ram_write_en),
    .ram_byte_en  (ram_byte_en),
    .ram_data     (ram_data)
  );

  // Environment RAM: synchronous, one-cycle read latency, byte-enabled writes.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_write_en) begin
      for (int b = 0; b < BW; b++)
        if (ram_byte_en[b]) mem[ram_addr[7:0]][b*8+:8] <= ram_write[b*8+:8];
    end
    ram_data <= mem[ram_addr[7:0]];
  end

  // Reference model: locked owner (-1 = none), search pointer, expected responses.
  int            m_lock;
  int            m_ptr;
  logic [N-1:0]  m_pend;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [256];
  int            m_grant;

  function automatic logic [DW-1:0] init_word(int a);
    return (32'(a) * 32'h0100_0193) ^ 32'hA5A5_0000;
  endfunction

  function automatic int model_grant();
    if (rst) return -1;
    if (m_lock >= 0) return req_valid[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic settle_check();
    logic [N-1:0]  e_ready;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wr;
    logic          e_we;
    logic [BW-1:0] e_be;
    logic [N-1:0]  e_rsp;
    #1;
    m_grant = model_grant();
    e_ready = '0;
    e_addr  = '0;
    e_wr    = '0;
    e_we    = 1'b0;
    e_be    = '0;
    if (m_grant >= 0) begin
      e_ready = N'(1) << m_grant;
      e_addr  = req_addr[m_grant];
      if (req_we[m_grant]) begin
        e_we = 1'b1;
        e_be = req_byte_en[m_grant];
        e_wr = req_wdata[m_grant];
      end
    end
    e_rsp = rst ? '0 : m_pend;
    chk("req_ready", 64'(req_ready), 64'(e_ready));
    chk("ram_addr", 64'(ram_addr), 64'(e_addr));
    chk("ram_write_en", 64'(ram_write_en), 64'(e_we));
    chk("ram_byte_en", 64'(ram_byte_en), 64'(e_be));
    chk("ram_write", 64'(ram_write), 64'(e_wr));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    if (e_rsp != '0) chk("rsp_data", 64'(rsp_data), 64'(m_pend_data));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_lock = -1;
      m_ptr  = 0;
      m_pend = '0;
    end else begin
      m_pend = '0;
      if (m_grant >= 0) begin
        if (req_we[m_grant]) begin
          for (int b = 0; b < BW; b++)
            if (req_byte_en[m_grant][b])
              m_mem[req_addr[m_grant][7:0]][b*8+:8] = req_wdata[m_grant][b*8+:8];
        end else begin
          m_pend[m_grant] = 1'b1;
          m_pend_data     = m_mem[req_addr[m_grant][7:0]];
        end
        if (req_last[m_grant]) begin
          m_lock = -1;
          m_ptr  = (m_grant + 1) % N;
        end else begin
          m_lock = m_grant;
        end
      end
    end
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  valid;
    logic [N-1:0]  we;
    logic [N-1:0]  last;
    logic [AW-1:0] addr;
    logic [N-1:0]  exp_ready;
    logic          exp_we;
  } vec_t;

  vec_t vt[$];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]   = init_word(i);
      m_mem[i] = init_word(i);
    end
    m_lock = -1; m_ptr = 0; m_pend = '0; m_pend_data = '0; m_grant = -1;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_last = '0;
    req_addr = '0; req_wdata = '0; req_byte_en = '0;

    @(negedge clk);
    settle_check();
    tick();
    tick();

    // Single read right after reset.
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0001; req_we = '0; req_last = 4'b0001;
    req_addr[0] = 16'h0010;
    settle_check();
    chk("single_ready", 64'(req_ready), 64'(4'b0001));
    chk("single_addr", 64'(ram_addr), 64'(16'h0010));
    tick();
    @(negedge clk);
    req_valid = '0;
    settle_check();
    chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
    chk("single_rsp_data", 64'(rsp_data), 64'(init_word(16)));
    tick();

    // rst valid we last addr exp_ready exp_we
    vt.push_back('{1'b1, 4'b1111, 4'b1010, 4'b1111, 16'h0030, 4'b0000, 1'b0});
    for (int r = 0; r < 8; r++)
      vt.push_back('{1'b0, 4'b1111, 4'b1010, 4'b1111, 16'h0030,
                     4'(1 << (r % 4)), 1'(r % 2)});
    vt.push_back('{1'b0, 4'b0110, 4'b0010, 4'b0000, 16'h0020, 4'b0010, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 4'b0010, 4'b0000, 16'h0021, 4'b0010, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 4'b0010, 4'b0000, 16'h0022, 4'b0010, 1'b1});
    vt.push_back('{1'b0, 4'b0110, 4'b0010, 4'b0010, 16'h0023, 4'b0010, 1'b1});
    vt.push_back('{1'b0, 4'b0100, 4'b0000, 4'b0100, 16'h0040, 4'b0100, 1'b0});
    vt.push_back('{1'b0, 4'b1001, 4'b1001, 4'b0000, 16'h0050, 4'b1000, 1'b1});
    vt.push_back('{1'b0, 4'b0001, 4'b1001, 4'b0000, 16'h0051, 4'b0000, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b1001, 4'b0000, 16'h0051, 4'b0000, 1'b0});
    vt.push_back('{1'b0, 4'b0001, 4'b1001, 4'b0000, 16'h0051, 4'b0000, 1'b0});
    vt.push_back('{1'b0, 4'b1001, 4'b1001, 4'b1000, 16'h0052, 4'b1000, 1'b1});
    vt.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0001, 16'h0053, 4'b0001, 1'b0});
    vt.push_back('{1'b0, 4'b0010, 4'b0000, 4'b0000, 16'h0060, 4'b0010, 1'b0});
    vt.push_back('{1'b1, 4'b0010, 4'b0000, 4'b0000, 16'h0061, 4'b0000, 1'b0});
    vt.push_back('{1'b0, 4'b0011, 4'b0000, 4'b0011, 16'h0062, 4'b0001, 1'b0});

    foreach (vt[r]) begin
      @(negedge clk);
      rst = vt[r].rst;
      req_valid = vt[r].valid;
      req_we    = vt[r].we;
      req_last  = vt[r].last;
      for (int i = 0; i < N; i++) begin
        req_addr[i]    = vt[r].addr;
        req_wdata[i]   = $urandom;
        req_byte_en[i] = 4'($urandom_range(1, 15));
      end
      settle_check();
      chk($sformatf("vec%0d_ready", r), 64'(req_ready), 64'(vt[r].exp_ready));
      chk($sformatf("vec%0d_we", r), 64'(ram_write_en), 64'(vt[r].exp_we));
      chk($sformatf("vec%0d_addr", r), 64'(ram_addr),
          64'((vt[r].exp_ready != '0) ? vt[r].addr : 16'h0000));
      tick();
    end

    // Random traffic with occasional reset.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i]   = 1'($urandom_range(0, 2) != 0);
        req_we[i]      = 1'($urandom);
        req_last[i]    = ($urandom_range(0, 2) == 0);
        req_addr[i]    = 16'($urandom_range(0, 255));
        req_wdata[i]   = $urandom;
        req_byte_en[i] = 4'($urandom);
      end
      settle_check();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
